// File: rtl/addsub_seq.sv
// Sequential adder/subtractor: processes one K-bit slice per clock with a
// four-phase req/fin handshake; flags are produced from the complete result.
module addsub_seq #(
    parameter int unsigned N = 32,
    parameter int unsigned K = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         op,
    input  logic         cin,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         fin,
    output logic [N-1:0] so,
    output logic         couto,
    output logic         ovf,
    output logic         zero,
    output logic         busy
);

    localparam int unsigned S  = N / K;
    localparam int unsigned IW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   xr_q, xr_d;
    logic [N-1:0]   yr_q, yr_d;
    logic           opr_q, opr_d;
    logic           carry_q, carry_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N-1:0]   so_q, so_d;
    logic           couto_q, couto_d;
    logic           ovf_q, ovf_d;
    logic           zero_q, zero_d;
    logic           fin_q, fin_d;

    logic [K:0]     sum;
    logic [K-1:0]   yslice;
    int unsigned    base;

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        opr_d   = opr_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        so_d    = so_q;
        couto_d = couto_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        fin_d   = fin_q;

        base   = K * 32'(idx_q);
        // Subtract runs as x + ~y + ~cin through the same carry chain.
        yslice = opr_q ? ~yr_q[base +: K] : yr_q[base +: K];
        sum    = {1'b0, xr_q[base +: K]} + {1'b0, yslice} + {{K{1'b0}}, carry_q};

        unique case (state_q)
            StIdle: begin
                if (req && !fin_q) begin
                    xr_d    = x;
                    yr_d    = y;
                    opr_d   = op;
                    carry_d = op ? ~cin : cin;
                    idx_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                so_d[base +: K] = sum[K-1:0];
                carry_d         = sum[K];
                idx_d           = idx_q + 1'b1;
                if (idx_q == IW'(S - 1)) begin
                    idx_d   = '0;
                    couto_d = opr_q ^ sum[K];
                    ovf_d   = opr_q ? ((xr_q[N-1] != yr_q[N-1]) && (so_d[N-1] != xr_q[N-1]))
                                    : ((xr_q[N-1] == yr_q[N-1]) && (so_d[N-1] != xr_q[N-1]));
                    zero_d  = (so_d == '0);
                    fin_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!req) begin
                    fin_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            xr_q    <= '0;
            yr_q    <= '0;
            opr_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            so_q    <= '0;
            couto_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            opr_q   <= opr_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            so_q    <= so_d;
            couto_q <= couto_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            fin_q   <= fin_d;
        end
    end

    assign fin   = fin_q;
    assign so    = so_q;
    assign couto = couto_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq (N=32, K=8): directed vectors push expected
// results; a monitor pops and compares on every rising fin.
module tb_addsub_seq;

    localparam int unsigned N = 32;
    localparam int unsigned K = 8;

    logic         clk = 1'b0;
    logic         rst, req, op, cin;
    logic [N-1:0] x, y;
    logic         fin, couto, ovf, zero, busy;
    logic [N-1:0] so;

    typedef struct packed {
        logic [N-1:0] so;
        logic         couto;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    addsub_seq #(.N(N), .K(K)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .op    (op),
        .cin   (cin),
        .x     (x),
        .y     (y),
        .fin   (fin),
        .so    (so),
        .couto (couto),
        .ovf   (ovf),
        .zero  (zero),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Monitor: compare each completed result against the oldest expectation.
    initial begin
        logic fin_prev;
        exp_t e;
        fin_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (fin === 1'b1 && fin_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_fin: got fin=1 so=%h, expected no result", so);
                end else begin
                    e = exp_q.pop_front();
                    chk("so", 64'(so), 64'(e.so));
                    chk("couto", 64'(couto), 64'(e.couto));
                    chk("ovf", 64'(ovf), 64'(e.ovf));
                    chk("zero", 64'(zero), 64'(e.zero));
                end
            end
            fin_prev = fin;
        end
    end

    // Wait for fin with a bound; returns number of edges seen.
    task automatic wait_fin(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (fin !== 1'b1 && n < 20);
    endtask

    // Full handshake: req held until fin plus `hold` extra edges, then released.
    task automatic run_op(input logic o, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic c, input exp_t e, input int hold);
        int n;
        @(negedge clk);
        op = o; x = a; y = b; cin = c; req = 1'b1;
        exp_q.push_back(e);
        wait_fin(n);
        chk("latency_edges", 64'(n), 64'd5);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("fin_held", 64'(fin), 64'd1);
        end
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        chk("fin_fall", 64'(fin), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; req = 1'b1; op = 1'b1; cin = 1'b0; x = 32'd5; y = 32'd3;

        // Reset held two edges with req high: everything stays cleared.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_outs", 64'({fin, couto, ovf, zero, busy}), 64'd0);
            chk("rst_so", 64'(so), 64'd0);
        end

        // First capture on the first edge with rst low; req stays high.
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{so: 32'h2, couto: 1'b0, ovf: 1'b0, zero: 1'b0});
        wait_fin(n);
        chk("latency_first", 64'(n), 64'd5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("fin_held_no_restart", 64'({fin, busy}), 64'b11);
        end
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        chk("fin_fall_first", 64'(fin), 64'd0);

        run_op(1'b1, 32'h0, 32'h1, 1'b0, '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}, 0);
        run_op(1'b1, 32'h80000000, 32'h1, 1'b0, '{32'h7FFFFFFF, 1'b0, 1'b1, 1'b0}, 1);
        run_op(1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}, 0);
        run_op(1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0}, 0);
        run_op(1'b0, 32'h12345678, 32'h0F0F0F0F, 1'b1, '{32'h21436588, 1'b0, 1'b0, 1'b0}, 0);
        run_op(1'b0, 32'h000000FF, 32'h1, 1'b0, '{32'h00000100, 1'b0, 1'b0, 1'b0}, 0);
        run_op(1'b1, 32'hA, 32'h3, 1'b1, '{32'h6, 1'b0, 1'b0, 1'b0}, 0);
        run_op(1'b1, 32'h3, 32'h5, 1'b0, '{32'hFFFFFFFE, 1'b1, 1'b0, 1'b0}, 0);

        // Abort: reset on the 3rd edge after capture, no fin pulse allowed.
        @(negedge clk);
        op = 1'b0; x = 32'd9; y = 32'd9; cin = 1'b0; req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_outs", 64'({fin, couto, ovf, zero, busy}), 64'd0);
        chk("abort_so", 64'(so), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 32'd2, 32'd2, 1'b0, '{32'd4, 1'b0, 1'b0, 1'b0}, 0);

        // One-edge req pulse; operands change right after capture.
        @(negedge clk);
        op = 1'b0; x = 32'd7; y = 32'd1; cin = 1'b0; req = 1'b1;
        exp_q.push_back('{so: 32'd8, couto: 1'b0, ovf: 1'b0, zero: 1'b0});
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; x = 32'd0; y = 32'hFFFFFFFF;
        wait_fin(n);
        chk("pulse_latency", 64'(n + 1), 64'd5);
        @(posedge clk);
        #1;
        chk("pulse_fin_one_cycle", 64'(fin), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
